// File: rtl/multdiv_issue_pkg.sv
// ============================================================================
// multdiv_issue_pkg : shared types and constants for the mult/div issue block
// Rev 1.0
// ============================================================================
`default_nettype none

package multdiv_issue_pkg;

   localparam int DATA_W              = 32;
   localparam int RD_W                = 5;
   localparam int CNT_W               = 8;
   localparam int TIMEOUT_CYCLES_DFLT = 40;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/multdiv_issue_if.sv
// ============================================================================
// multdiv_issue_if : issue, unit-side and writeback signals of the controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface multdiv_issue_if;
   import multdiv_issue_pkg::*;

   logic              issue_valid;
   logic              issue_is_div;
   logic [DATA_W-1:0] issue_a;
   logic [DATA_W-1:0] issue_b;
   logic [RD_W-1:0]   issue_rd;
   logic              issue_ready;
   logic              flush;
   logic              stall;
   logic [DATA_W-1:0] md_operandA;
   logic [DATA_W-1:0] md_operandB;
   logic              md_ctrl_MULT;
   logic              md_ctrl_DIV;
   logic [DATA_W-1:0] md_result;
   logic              md_exception;
   logic              md_resultRDY;
   logic              wb_valid;
   logic [RD_W-1:0]   wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              wb_exception;

   modport master (
      input  issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
             md_result, md_exception, md_resultRDY,
      output issue_ready, stall, md_operandA, md_operandB, md_ctrl_MULT,
             md_ctrl_DIV, wb_valid, wb_rd, wb_data, wb_exception
   );

   modport slave (
      output issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
             md_result, md_exception, md_resultRDY,
      input  issue_ready, stall, md_operandA, md_operandB, md_ctrl_MULT,
             md_ctrl_DIV, wb_valid, wb_rd, wb_data, wb_exception
   );

endinterface

`default_nettype wire

// File: rtl/multdiv_issue_md_wait_counter.sv
// ============================================================================
// md_wait_counter : clearable wait-cycle counter with terminal-count flag
// Rev 1.0
// ============================================================================
`default_nettype none

module md_wait_counter #(
   parameter int CNT_W = 8,
   parameter int LIMIT = 40
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   logic [CNT_W-1:0] r_count;

   // Holds at the terminal value so the flag stays asserted until cleared.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_terminal) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_terminal = (r_count == CNT_W'(LIMIT));

endmodule

`default_nettype wire

// File: rtl/multdiv_issue.sv
// ============================================================================
// multdiv_issue : issues one MULT/DIV to the multicycle unit, stalls, writes back
// Optional wait timeout compiled in with MULTDIV_ISSUE_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module multdiv_issue
   import multdiv_issue_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
   input  logic            clock,
   input  logic            reset_n,
   multdiv_issue_if.master bus
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
      $error("multdiv_issue: TIMEOUT_CYCLES must be within 2..255");
   end

   state_t            r_state;
   logic              r_isDiv;
   logic [DATA_W-1:0] r_opA;
   logic [DATA_W-1:0] r_opB;
   logic [RD_W-1:0]   r_rd;
   logic              r_wbValid;
   logic [DATA_W-1:0] r_wbData;
   logic              r_wbExc;
   logic              w_accept;
   logic              w_timeout;

   assign w_accept = (r_state == IDLE) && bus.issue_valid && !bus.flush;

`ifdef MULTDIV_ISSUE_TIMEOUT_EN
   md_wait_counter #(
      .CNT_W (CNT_W),
      .LIMIT (TIMEOUT_CYCLES)
   ) u_waitCounter (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_clear    (r_state == START),
      .i_enable   (r_state == WAIT),
      .o_terminal (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_isDiv   <= 1'b0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_rd      <= '0;
         r_wbValid <= 1'b0;
         r_wbData  <= '0;
         r_wbExc   <= 1'b0;
      end else begin
         r_wbValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_isDiv <= bus.issue_is_div;
                  r_opA   <= bus.issue_a;
                  r_opB   <= bus.issue_b;
                  r_rd    <= bus.issue_rd;
                  r_state <= START;
               end
            end
            START: begin
               r_state <= bus.flush ? IDLE : WAIT;
            end
            WAIT: begin
               // Result ready beats a coinciding timeout.
               if (bus.flush) begin
                  r_state <= IDLE;
               end else if (bus.md_resultRDY) begin
                  r_wbData  <= bus.md_result;
                  r_wbExc   <= bus.md_exception;
                  r_wbValid <= 1'b1;
                  r_state   <= DONE;
               end else if (w_timeout) begin
                  r_wbData  <= '0;
                  r_wbExc   <= 1'b1;
                  r_wbValid <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.issue_ready  = (r_state == IDLE);
   assign bus.stall        = (r_state != IDLE) || w_accept;
   assign bus.md_ctrl_MULT = (r_state == START) && !r_isDiv;
   assign bus.md_ctrl_DIV  = (r_state == START) && r_isDiv;
   assign bus.md_operandA  = r_opA;
   assign bus.md_operandB  = r_opB;
   assign bus.wb_valid     = r_wbValid;
   assign bus.wb_rd        = r_rd;
   assign bus.wb_data      = r_wbData;
   assign bus.wb_exception = r_wbExc;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_issue.sv
// ============================================================================
// tb_multdiv_issue : directed scoreboard bench for multdiv_issue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_issue;
   import multdiv_issue_pkg::*;

   localparam int TO = 40;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        exc;
      int          at;
   } wb_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   cyc     = 0;
   int   nChecks = 0;
   int   nPass   = 0;
   wb_t  sbQ[$];

   multdiv_issue_if bus();

   multdiv_issue #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Writeback monitor: every wb_valid must match the oldest expected record.
   initial begin
      wb_t e;
      forever begin
         @(negedge clock);
         if (reset_n && bus.wb_valid === 1'b1) begin
            if (sbQ.size() == 0) begin
               nChecks++;
               $display("FAIL wb_unexpected: wb_valid at cycle %0d rd=%0d data=0x%0h, expected no writeback",
                        cyc, bus.wb_rd, bus.wb_data);
            end else begin
               e = sbQ.pop_front();
               chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
               chk("wb_data", bus.wb_data, e.data);
               chk("wb_exception", 32'(bus.wb_exception), 32'(e.exc));
               chk("wb_cycle", 32'(cyc), 32'(e.at));
            end
         end
      end
   end

   // One operation from acceptance (cycle 0). rdyCyc<0: no RDY; flushCyc>=0: flush then RDY 2 cycles later.
   task automatic runOp(input string nm, input logic isDiv, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int rdyCyc, input logic [31:0] res, input logic exc,
                        input logic staleRdy, input int flushCyc, input int bound);
      int   t0;
      int   pulses;
      logic stable;
      logic stallOk;
      logic wbSeen;
      logic expectWb;
      wb_t  e;
      pulses   = 0;
      stable   = 1'b1;
      stallOk  = 1'b1;
      wbSeen   = 1'b0;
      expectWb = (flushCyc < 0);
      @(posedge clock); #1;
      t0 = cyc;
      bus.issue_valid  = 1'b1;
      bus.issue_is_div = isDiv;
      bus.issue_a      = a;
      bus.issue_b      = b;
      bus.issue_rd     = rd;
      bus.md_resultRDY = staleRdy;
      bus.md_result    = 32'hDEADBEEF;
      bus.md_exception = staleRdy;
      if (expectWb) begin
         e.rd   = rd;
         e.data = (rdyCyc >= 0) ? res : 32'h0;
         e.exc  = (rdyCyc >= 0) ? exc : 1'b1;
         e.at   = t0 + ((rdyCyc >= 0) ? rdyCyc + 1 : TO + 3);
         sbQ.push_back(e);
      end
      @(negedge clock);
      chk({nm, "_c0_ready"}, 32'(bus.issue_ready), 32'd1);
      chk({nm, "_c0_stall"}, 32'(bus.stall), 32'd1);
      for (int c = 1; c <= bound; c++) begin
         @(posedge clock); #1;
         bus.issue_valid  = 1'b0;
         bus.md_resultRDY = (c == rdyCyc) || (staleRdy && c < 2) || (flushCyc >= 0 && c == flushCyc + 2);
         bus.md_result    = (c == rdyCyc) ? res : 32'hDEADBEEF;
         bus.md_exception = (c == rdyCyc) ? exc : 1'b1;
         bus.flush        = (c == flushCyc);
         @(negedge clock);
         pulses += int'(bus.md_ctrl_MULT) + int'(bus.md_ctrl_DIV);
         if (c == 1) begin
            chk({nm, "_c1_mult"}, 32'(bus.md_ctrl_MULT), 32'(!isDiv));
            chk({nm, "_c1_div"}, 32'(bus.md_ctrl_DIV), 32'(isDiv));
         end
         if (bus.md_operandA !== a || bus.md_operandB !== b) stable = 1'b0;
         if ((flushCyc < 0 || c <= flushCyc) && bus.stall !== 1'b1) stallOk = 1'b0;
         if (flushCyc >= 0 && c == flushCyc + 1) begin
            chk({nm, "_flushed_ready"}, 32'(bus.issue_ready), 32'd1);
            chk({nm, "_flushed_stall"}, 32'(bus.stall), 32'd0);
         end
         if (bus.wb_valid === 1'b1) begin
            wbSeen = 1'b1;
            chk({nm, "_done_ready"}, 32'(bus.issue_ready), 32'd0);
            break;
         end
      end
      bus.md_resultRDY = 1'b0;
      bus.flush        = 1'b0;
      chk({nm, "_start_pulses"}, 32'(pulses), 32'd1);
      chk({nm, "_operands_held"}, 32'(stable), 32'd1);
      chk({nm, "_stall_held"}, 32'(stallOk), 32'd1);
      chk({nm, "_wb_seen"}, 32'(wbSeen), 32'(expectWb));
      if (expectWb && !wbSeen && sbQ.size() > 0) void'(sbQ.pop_back());
      @(posedge clock); #1;
      @(negedge clock);
      chk({nm, "_after_ready"}, 32'(bus.issue_ready), 32'd1);
      chk({nm, "_after_stall"}, 32'(bus.stall), 32'd0);
   endtask

   task automatic chkResetOutputs(input string nm);
      chk({nm, "_ready"}, 32'(bus.issue_ready), 32'd1);
      chk({nm, "_stall"}, 32'(bus.stall), 32'd0);
      chk({nm, "_ctrl"}, 32'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 32'd0);
      chk({nm, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
      chk({nm, "_opA"}, bus.md_operandA, 32'd0);
      chk({nm, "_opB"}, bus.md_operandB, 32'd0);
      chk({nm, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
      chk({nm, "_wb_data"}, bus.wb_data, 32'd0);
      chk({nm, "_wb_exc"}, 32'(bus.wb_exception), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
      $fatal(1);
   end

   initial begin
      bus.issue_valid  = 1'b0;
      bus.issue_is_div = 1'b0;
      bus.issue_a      = '0;
      bus.issue_b      = '0;
      bus.issue_rd     = '0;
      bus.flush        = 1'b0;
      bus.md_result    = '0;
      bus.md_exception = 1'b0;
      bus.md_resultRDY = 1'b0;
      reset_n          = 1'b0;
      repeat (3) @(negedge clock);
      chkResetOutputs("por");
      reset_n = 1'b1;

      runOp("mul",       1'b0, 32'd7,   32'hFFFFFFFD, 5'd5,  34, 32'hFFFFFFEB, 1'b0, 1'b0, -1, 40);
      runOp("divzero",   1'b1, 32'd100, 32'd0,        5'd2,  20, 32'h0,        1'b1, 1'b0, -1, 25);
      runOp("stale",     1'b0, 32'd9,   32'd4,        5'd7,  6,  32'd36,       1'b0, 1'b1, -1, 12);
      runOp("flush",     1'b1, 32'd50,  32'd5,        5'd3,  -1, 32'd0,        1'b0, 1'b0, 10, 14);
      runOp("postflush", 1'b0, 32'd3,   32'd11,       5'd12, 4,  32'd33,       1'b0, 1'b0, -1, 10);
      runOp("rdzero",    1'b0, 32'd6,   32'd7,        5'd0,  3,  32'd42,       1'b0, 1'b0, -1, 8);

      // Asynchronous reset while waiting on the unit.
      @(posedge clock); #1;
      bus.issue_valid  = 1'b1;
      bus.issue_is_div = 1'b1;
      bus.issue_a      = 32'd100;
      bus.issue_b      = 32'd7;
      bus.issue_rd     = 5'd9;
      @(posedge clock); #1;
      bus.issue_valid = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      chk("pre_reset_stall", 32'(bus.stall), 32'd1);
      reset_n = 1'b0;
      #1;
      chkResetOutputs("async");
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_reset_ready", 32'(bus.issue_ready), 32'd1);

      runOp("div14", 1'b1, 32'd100, 32'd7, 5'd9, 8, 32'd14, 1'b0, 1'b0, -1, 14);
`ifdef MULTDIV_ISSUE_TIMEOUT_EN
      runOp("timeout", 1'b0, 32'd5, 32'd6, 5'd4, -1, 32'd0, 1'b0, 1'b0, -1, 50);
`else
      runOp("notimeout", 1'b0, 32'd5, 32'd6, 5'd4, -1, 32'd0, 1'b0, 1'b0, 60, 62);
`endif
      chk("sb_drained", 32'(sbQ.size()), 32'd0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

`default_nettype wire
